// File: rtl/nw_traceback.sv
// rtl/nw_traceback.sv - Needleman-Wunsch traceback engine streaming aligned pairs from (N,N) back to (0,0)
module nw_traceback #(
    parameter int N        = 8,
    parameter int SCORE_W  = 8,
    parameter int ADDR_W   = $clog2((N + 1) * (N + 1)),
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int GAP      = -2,
    localparam int LEN_W   = $clog2(2 * N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_traceB,
    input  logic [2*N-1:0]     seq_a,
    input  logic [2*N-1:0]     seq_b,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [SCORE_W-1:0] rd_data,
    output logic               out_valid,
    output logic [2:0]         out_a,
    output logic [2:0]         out_b,
    output logic [1:0]         out_op,
    output logic [LEN_W-1:0]   align_len,
    output logic               end_traceB
);

    localparam int IW = $clog2(N + 1);
    localparam int EW = SCORE_W + 2;
    localparam logic signed [EW-1:0] MATCH_E    = EW'(MATCH);
    localparam logic signed [EW-1:0] MISMATCH_E = EW'(MISMATCH);
    localparam logic signed [EW-1:0] GAP_E      = EW'(GAP);

    typedef enum logic [3:0] {
        IDLE, LOAD, CAPT, STEP, RD_UP, RD_LEFT, DEC, DONE, WAIT_REL
    } state_t;

    state_t             state, nxt_state;
    logic [IW-1:0]      i, j, nxt_i, nxt_j;
    logic [SCORE_W-1:0] cur, d, u;
    logic [1:0]         dec_op;
    logic               chars_eq;
    logic signed [EW-1:0] s_e;
    logic [1:0]         a_i, b_j, a_ni, b_nj;

    logic               rd_en_d, out_valid_d, end_d, emit;
    logic [ADDR_W-1:0]  rd_addr_d;
    logic [2:0]         out_a_d, out_b_d;
    logic [1:0]         out_op_d;
    logic [LEN_W-1:0]   align_len_d;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IW-1:0] ii, input logic [IW-1:0] jj);
        return ADDR_W'(int'(ii) * (N + 1) + int'(jj));
    endfunction

    // Character k is 1-based; k=0 yields 00 and is never consumed.
    function automatic logic [1:0] chr(input logic [2*N-1:0] s, input logic [IW-1:0] k);
        logic [2*N+1:0] t;
        t = {s, 2'b00} >> (2 * k);
        return t[1:0];
    endfunction

    function automatic logic signed [EW-1:0] sx(input logic [SCORE_W-1:0] v);
        return {{2{v[SCORE_W-1]}}, v};
    endfunction

    assign a_i  = chr(seq_a, i);
    assign b_j  = chr(seq_b, j);
    assign a_ni = chr(seq_a, nxt_i);
    assign b_nj = chr(seq_b, nxt_j);

    // Evaluated in RD_LEFT, where rd_data carries the up-neighbour score.
    // Left is the fallback, so the left score is not needed for the decision.
    always_comb begin
        chars_eq = (a_i == b_j);
        s_e      = chars_eq ? MATCH_E : MISMATCH_E;
        if (sx(cur) == sx(d) + s_e)
            dec_op = chars_eq ? 2'b00 : 2'b01;
        else if (sx(cur) == sx(rd_data) + GAP_E)
            dec_op = 2'b10;
        else
            dec_op = 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        nxt_i     = i;
        nxt_j     = j;
        case (state)
            IDLE: begin
                if (en_traceB) begin
                    nxt_state = LOAD;
                    nxt_i     = IW'(N);
                    nxt_j     = IW'(N);
                end
            end
            LOAD:    nxt_state = CAPT;
            CAPT:    nxt_state = STEP;
            STEP: begin
                if (i == '0 && j == '0)
                    nxt_state = DONE;
                else if (i == '0)
                    nxt_j = j - 1'b1;
                else if (j == '0)
                    nxt_i = i - 1'b1;
                else
                    nxt_state = RD_UP;
            end
            RD_UP:   nxt_state = RD_LEFT;
            RD_LEFT: nxt_state = DEC;
            DEC: begin
                nxt_state = STEP;
                if (out_op != 2'b11)
                    nxt_i = i - 1'b1;
                if (out_op != 2'b10)
                    nxt_j = j - 1'b1;
            end
            DONE:    nxt_state = WAIT_REL;
            WAIT_REL: begin
                if (!en_traceB)
                    nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
        if (!en_traceB && state != IDLE && state != WAIT_REL)
            nxt_state = IDLE;
    end

    // Outputs are registered, so they are derived from the state and
    // coordinates the engine is about to enter.
    always_comb begin
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr;
        out_valid_d = 1'b0;
        out_a_d     = out_a;
        out_b_d     = out_b;
        out_op_d    = out_op;
        align_len_d = align_len;
        end_d       = 1'b0;
        emit        = 1'b0;
        case (nxt_state)
            LOAD: begin
                rd_en_d     = 1'b1;
                rd_addr_d   = addr_of(IW'(N), IW'(N));
                align_len_d = '0;
            end
            STEP: begin
                if (nxt_i != '0 && nxt_j != '0) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_of(nxt_i - 1'b1, nxt_j - 1'b1);
                end else if (nxt_i == '0 && nxt_j != '0) begin
                    emit     = 1'b1;
                    out_a_d  = 3'b100;
                    out_b_d  = {1'b0, b_nj};
                    out_op_d = 2'b11;
                end else if (nxt_j == '0 && nxt_i != '0) begin
                    emit     = 1'b1;
                    out_a_d  = {1'b0, a_ni};
                    out_b_d  = 3'b100;
                    out_op_d = 2'b10;
                end
            end
            RD_UP: begin
                rd_en_d   = 1'b1;
                rd_addr_d = addr_of(i - 1'b1, j);
            end
            RD_LEFT: begin
                rd_en_d   = 1'b1;
                rd_addr_d = addr_of(i, j - 1'b1);
            end
            DEC: begin
                emit     = 1'b1;
                out_op_d = dec_op;
                out_a_d  = (dec_op == 2'b11) ? 3'b100 : {1'b0, a_i};
                out_b_d  = (dec_op == 2'b10) ? 3'b100 : {1'b0, b_j};
            end
            DONE:    end_d = 1'b1;
            default: ;
        endcase
        if (emit) begin
            out_valid_d = 1'b1;
            align_len_d = align_len + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i          <= '0;
            j          <= '0;
            cur        <= '0;
            d          <= '0;
            u          <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_op     <= '0;
            align_len  <= '0;
            end_traceB <= 1'b0;
        end else begin
            i          <= nxt_i;
            j          <= nxt_j;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            out_valid  <= out_valid_d;
            out_a      <= out_a_d;
            out_b      <= out_b_d;
            out_op     <= out_op_d;
            align_len  <= align_len_d;
            end_traceB <= end_d;
            case (state)
                CAPT:    cur <= rd_data;
                RD_UP:   d   <= rd_data;
                RD_LEFT: u   <= rd_data;
                DEC: begin
                    case (out_op)
                        2'b10:   cur <= u;
                        2'b11:   cur <= rd_data;
                        default: cur <= d;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_traceback.sv
// tb/tb_nw_traceback.sv - self-checking bench for nw_traceback
module tb_nw_traceback;
    localparam int N     = 2;
    localparam int SW    = 8;
    localparam int AW    = $clog2((N + 1) * (N + 1));
    localparam int LW    = $clog2(2 * N + 1);
    localparam int CELLS = (N + 1) * (N + 1);

    typedef logic [CELLS-1:0][7:0] mat_t;
    typedef struct {
        logic [2*N-1:0]  sa;
        logic [2*N-1:0]  sb;
        mat_t            m;
        int              n;
        logic [3:0][1:0] ops;
        logic [3:0][2:0] pa;
        logic [3:0][2:0] pb;
        int              cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [2*N-1:0] seq_a = '0, seq_b = '0;
    logic rd_en, out_valid, end_traceB;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_data = '0;
    logic [2:0] out_a, out_b;
    logic [1:0] out_op;
    logic [LW-1:0] align_len;

    logic en_ov = 1'b0;
    logic [2*N-1:0] seq_ov = '0;
    logic rd_en_ov, out_valid_ov, end_ov;
    logic [AW-1:0] rd_addr_ov;
    logic [3:0] rd_data_ov = '0;
    logic [2:0] out_a_ov, out_b_ov;
    logic [1:0] out_op_ov;
    logic [LW-1:0] align_len_ov;

    logic [SW-1:0] mem [CELLS];
    logic [3:0]    mem_ov [CELLS];

    int total = 0, bad = 0;
    int got_a[$], got_b[$], got_op[$];
    int exp_a[$], exp_b[$], exp_op[$];
    int exp_cyc, run_cyc;
    int hold_ends, hold_reads, hold_valids;
    vec_t tbl[3];

    nw_traceback #(.N(N), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .en_traceB(en), .seq_a(seq_a), .seq_b(seq_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .align_len(align_len), .end_traceB(end_traceB)
    );

    nw_traceback #(.N(N), .SCORE_W(4)) dut_ov (
        .clk(clk), .rst(rst), .en_traceB(en_ov), .seq_a(seq_ov), .seq_b(seq_ov),
        .rd_en(rd_en_ov), .rd_addr(rd_addr_ov), .rd_data(rd_data_ov),
        .out_valid(out_valid_ov), .out_a(out_a_ov), .out_b(out_b_ov), .out_op(out_op_ov),
        .align_len(align_len_ov), .end_traceB(end_ov)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
    always @(posedge clk) if (rd_en_ov) rd_data_ov <= mem_ov[rd_addr_ov];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic mat_t mk(input int v[CELLS]);
        mat_t r;
        for (int k = 0; k < CELLS; k++) r[k] = 8'(v[k]);
        return r;
    endfunction

    function automatic logic [3:0][1:0] ops4(input int a, input int b, input int c, input int e);
        logic [3:0][1:0] r;
        r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(e);
        return r;
    endfunction

    function automatic logic [3:0][2:0] p4(input int a, input int b, input int c, input int e);
        logic [3:0][2:0] r;
        r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c); r[3] = 3'(e);
        return r;
    endfunction

    function automatic int sc(input int i, input int j);
        return int'($signed(mem[i * (N + 1) + j]));
    endfunction

    function automatic int ch(input logic [2*N-1:0] s, input int k);
        logic [2*N-1:0] t;
        t = s >> (2 * (k - 1));
        return int'(t[1:0]);
    endfunction

    // Reference traceback walked straight from the scoring rules.
    task automatic model(input logic [2*N-1:0] sa, input logic [2*N-1:0] sb);
        int i, j, cur, d, u, l, s;
        exp_a.delete(); exp_b.delete(); exp_op.delete();
        i = N; j = N; cur = sc(N, N); exp_cyc = 3;
        while (i > 0 || j > 0) begin
            if (i == 0) begin
                exp_a.push_back(4); exp_b.push_back(ch(sb, j)); exp_op.push_back(3);
                j--; exp_cyc += 1;
            end else if (j == 0) begin
                exp_a.push_back(ch(sa, i)); exp_b.push_back(4); exp_op.push_back(2);
                i--; exp_cyc += 1;
            end else begin
                s = (ch(sa, i) == ch(sb, j)) ? 1 : -1;
                d = sc(i - 1, j - 1); u = sc(i - 1, j); l = sc(i, j - 1);
                exp_cyc += 4;
                if (cur == d + s) begin
                    exp_a.push_back(ch(sa, i)); exp_b.push_back(ch(sb, j));
                    exp_op.push_back(s == 1 ? 0 : 1);
                    i--; j--; cur = d;
                end else if (cur == u - 2) begin
                    exp_a.push_back(ch(sa, i)); exp_b.push_back(4); exp_op.push_back(2);
                    i--; cur = u;
                end else begin
                    exp_a.push_back(4); exp_b.push_back(ch(sb, j)); exp_op.push_back(3);
                    j--; cur = l;
                end
            end
        end
    endtask

    task automatic fill_nw(input logic [2*N-1:0] sa, input logic [2*N-1:0] sb);
        int h[N+1][N+1];
        int m;
        for (int i = 0; i <= N; i++) begin
            for (int j = 0; j <= N; j++) begin
                if (i == 0) h[i][j] = -2 * j;
                else if (j == 0) h[i][j] = -2 * i;
                else begin
                    m = h[i-1][j-1] + ((ch(sa, i) == ch(sb, j)) ? 1 : -1);
                    if (h[i-1][j] - 2 > m) m = h[i-1][j] - 2;
                    if (h[i][j-1] - 2 > m) m = h[i][j-1] - 2;
                    h[i][j] = m;
                end
                mem[i * (N + 1) + j] = SW'(h[i][j]);
            end
        end
    endtask

    task automatic run_trace(input logic [2*N-1:0] sa, input logic [2*N-1:0] sb, input int hold);
        int load_t, done_t;
        got_a.delete(); got_b.delete(); got_op.delete();
        seq_a = sa; seq_b = sb;
        load_t = -1; done_t = -1;
        hold_ends = 0; hold_reads = 0; hold_valids = 0;
        en = 1'b1;
        for (int k = 0; k < 400 && done_t < 0; k++) begin
            @(negedge clk);
            if (rd_en && load_t < 0) load_t = k;
            if (out_valid) begin
                got_a.push_back(int'(out_a));
                got_b.push_back(int'(out_b));
                got_op.push_back(int'(out_op));
            end
            if (end_traceB) done_t = k;
        end
        check("run_done", int'(done_t >= 0), 1);
        run_cyc = done_t - load_t;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            hold_ends   += int'(end_traceB);
            hold_reads  += int'(rd_en);
            hold_valids += int'(out_valid);
        end
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, got_op.size(), exp_op.size());
        for (int k = 0; k < exp_op.size() && k < got_op.size(); k++) begin
            check($sformatf("%s_op%0d", tag, k), got_op[k], exp_op[k]);
            check($sformatf("%s_a%0d", tag, k), got_a[k], exp_a[k]);
            check($sformatf("%s_b%0d", tag, k), got_b[k], exp_b[k]);
        end
        check({tag, "_len"}, int'(align_len), exp_op.size());
        check({tag, "_cycles"}, run_cyc, exp_cyc);
    endtask

    initial begin
        int found, seen, first_op, ov_done, vsum, esum, rsum;
        logic [2*N-1:0] sa, sb;

        tbl[0].sa = 4'b0100; tbl[0].sb = 4'b0100;
        tbl[0].m  = mk('{0, -2, -4, -2, 1, -1, -4, -1, 2});
        tbl[0].n  = 2; tbl[0].ops = ops4(0, 0, 0, 0);
        tbl[0].pa = p4(1, 0, 0, 0); tbl[0].pb = p4(1, 0, 0, 0); tbl[0].cyc = 11;

        tbl[1].sa = 4'b0100; tbl[1].sb = 4'b1110;
        tbl[1].m  = mk('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl[1].n  = 4; tbl[1].ops = ops4(3, 3, 2, 2);
        tbl[1].pa = p4(4, 4, 1, 0); tbl[1].pb = p4(3, 2, 4, 4); tbl[1].cyc = 13;

        tbl[2].sa = 4'b0000; tbl[2].sb = 4'b0000;
        tbl[2].m  = mk('{-2, 0, 0, 0, -1, 2, 0, 0, 0});
        tbl[2].n  = 2; tbl[2].ops = ops4(0, 0, 0, 0);
        tbl[2].pa = p4(0, 0, 0, 0); tbl[2].pb = p4(0, 0, 0, 0); tbl[2].cyc = 11;

        repeat (2) @(negedge clk);
        check("reset_outputs", int'({rd_en, rd_addr, out_valid, out_a, out_b, out_op, align_len, end_traceB}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < CELLS; k++) mem[k] = tbl[t].m[k];
            exp_a.delete(); exp_b.delete(); exp_op.delete();
            for (int k = 0; k < tbl[t].n; k++) begin
                exp_op.push_back(int'(tbl[t].ops[k]));
                exp_a.push_back(int'(tbl[t].pa[k]));
                exp_b.push_back(int'(tbl[t].pb[k]));
            end
            exp_cyc = tbl[t].cyc;
            run_trace(tbl[t].sa, tbl[t].sb, 0);
            compare($sformatf("tbl%0d", t));
        end

        // Enable held well past DONE: single pulse, no reads, restart only after release.
        for (int k = 0; k < CELLS; k++) mem[k] = tbl[0].m[k];
        run_trace(tbl[0].sa, tbl[0].sb, 20);
        check("hold_extra_end", hold_ends, 0);
        check("hold_reads", hold_reads, 0);
        check("hold_valids", hold_valids, 0);
        en = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rd_en) seen = 1;
        end
        check("restart_after_release", seen, 1);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Abort in the RD_LEFT cycle of the second interior move.
        seq_a = tbl[0].sa; seq_b = tbl[0].sb;
        en = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (rd_en) found = 1;
        end
        check("abort_load_seen", found, 1);
        repeat (8) @(negedge clk);
        check("abort_rd_left_en", int'(rd_en), 1);
        check("abort_rd_left_addr", int'(rd_addr), 3);
        check("abort_len_before", int'(align_len), 1);
        en = 1'b0;
        vsum = 0; esum = 0; rsum = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vsum += int'(out_valid); esum += int'(end_traceB); rsum += int'(rd_en);
        end
        check("abort_valid", vsum, 0);
        check("abort_end", esum, 0);
        check("abort_reads", rsum, 0);
        check("abort_len_hold", int'(align_len), 1);

        // Asynchronous reset in the middle of a run.
        for (int k = 0; k < CELLS; k++) mem[k] = tbl[1].m[k];
        seq_a = tbl[1].sa; seq_b = tbl[1].sb;
        en = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("midrun_reset_outputs", int'({rd_en, rd_addr, out_valid, out_a, out_b, out_op, align_len, end_traceB}), 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < CELLS; k++) mem[k] = tbl[0].m[k];
        model(tbl[0].sa, tbl[0].sb);
        run_trace(tbl[0].sa, tbl[0].sb, 0);
        compare("post_reset");

        // Narrow scores: 7+1 must not alias to -8.
        for (int k = 0; k < CELLS; k++) mem_ov[k] = 4'h0;
        mem_ov[8] = 4'b1000;
        mem_ov[4] = 4'b0111;
        en_ov = 1'b1;
        first_op = -1; ov_done = 0;
        for (int k = 0; k < 80 && ov_done == 0; k++) begin
            @(negedge clk);
            if (out_valid_ov && first_op < 0) first_op = int'(out_op_ov);
            if (end_ov) ov_done = 1;
        end
        check("overflow_first_op", first_op, 3);
        check("overflow_done", ov_done, 1);
        en_ov = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 40; r++) begin
            sa = 4'($urandom);
            sb = 4'($urandom);
            if (r % 2 == 0)
                fill_nw(sa, sb);
            else
                for (int k = 0; k < CELLS; k++) mem[k] = SW'(int'($urandom_range(6, 0)) - 3);
            model(sa, sb);
            run_trace(sa, sb, 0);
            compare($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
